// File: rtl/dram_arbiter_if.sv
// Bus bundle between the two DRAM masters (CPU data port, DMA/loader), the arbiter and the RAM.
// The arbiter takes the slave view; the environment (masters plus RAM) takes the master view.
interface dram_arbiter_if #(
    parameter int AW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_ack;
    logic [31:0]   cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [31:0]   dma_wdata;
    logic          dma_ack;
    logic [31:0]   dma_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one async-read / sync-write data RAM between the CPU and a DMA master,
// with a hold limit so a streaming owner yields to a waiting master after MAX_HOLD accesses.
module dram_arbiter #(
    parameter int AW       = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic                fpga_clk,
    input  logic                fpga_rst,
    dram_arbiter_if.slave       bus,
    output logic [1:0]          owner
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OWN_CPU = 2'b01,
        ST_OWN_DMA = 2'b10
    } state_t;

    localparam int              HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic            LAST_CPU  = 1'b0;
    localparam logic            LAST_DMA  = 1'b1;

    state_t         state_q;
    state_t         state_d;
    logic           last_q;
    logic           last_d;
    logic [HCW-1:0] hold_cnt_q;
    logic [HCW-1:0] hold_cnt_d;

    function automatic logic [HCW-1:0] hold_inc(input logic [HCW-1:0] cnt);
        if (cnt == HOLD_LAST) begin
            return cnt;
        end else begin
            return cnt + {{(HCW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Ownership decisions are taken on the current cycle's requests and only take effect at the edge.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = {HCW{1'b0}};
                if (bus.cpu_req && bus.dma_req) begin
                    state_d = (last_q == LAST_DMA) ? ST_OWN_CPU : ST_OWN_DMA;
                end else if (bus.cpu_req) begin
                    state_d = ST_OWN_CPU;
                end else if (bus.dma_req) begin
                    state_d = ST_OWN_DMA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN_CPU: begin
                if (!bus.cpu_req) begin
                    state_d    = bus.dma_req ? ST_OWN_DMA : ST_IDLE;
                    last_d     = LAST_CPU;
                    hold_cnt_d = {HCW{1'b0}};
                end else if ((hold_cnt_q == HOLD_LAST) && bus.dma_req) begin
                    state_d    = ST_OWN_DMA;
                    last_d     = LAST_CPU;
                    hold_cnt_d = {HCW{1'b0}};
                end else begin
                    hold_cnt_d = hold_inc(hold_cnt_q);
                end
            end
            ST_OWN_DMA: begin
                if (!bus.dma_req) begin
                    state_d    = bus.cpu_req ? ST_OWN_CPU : ST_IDLE;
                    last_d     = LAST_DMA;
                    hold_cnt_d = {HCW{1'b0}};
                end else if ((hold_cnt_q == HOLD_LAST) && bus.cpu_req) begin
                    state_d    = ST_OWN_CPU;
                    last_d     = LAST_DMA;
                    hold_cnt_d = {HCW{1'b0}};
                end else begin
                    hold_cnt_d = hold_inc(hold_cnt_q);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = {HCW{1'b0}};
            end
        endcase
    end

    // Arbiter state; after reset the CPU wins the first tie.
    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            state_q    <= ST_IDLE;
            last_q     <= LAST_DMA;
            hold_cnt_q <= {HCW{1'b0}};
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // RAM mux and returns; acks and write enable are gated by reset so a mid-burst reset cannot write.
    always_comb begin
        bus.mem_addr  = {AW{1'b0}};
        bus.mem_wdata = 32'h0000_0000;
        bus.mem_we    = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_rdata = 32'h0000_0000;
        bus.dma_ack   = 1'b0;
        bus.dma_rdata = 32'h0000_0000;
        case (state_q)
            ST_OWN_CPU: begin
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
                bus.mem_we    = bus.cpu_we & bus.cpu_req & ~fpga_rst;
                bus.cpu_ack   = bus.cpu_req & ~fpga_rst;
                bus.cpu_rdata = bus.mem_rdata;
            end
            ST_OWN_DMA: begin
                bus.mem_addr  = bus.dma_addr;
                bus.mem_wdata = bus.dma_wdata;
                bus.mem_we    = bus.dma_we & bus.dma_req & ~fpga_rst;
                bus.dma_ack   = bus.dma_req & ~fpga_rst;
                bus.dma_rdata = bus.mem_rdata;
            end
            default: begin
                bus.mem_we = 1'b0;
            end
        endcase
    end

    assign owner = state_q;

endmodule
